// File: rtl/mmio_pkg.sv
// Shared address map, readdata field layout and decoder for the MMIO responder.
package mmio_pkg;

  localparam logic [31:0] LED          = 32'hFFFF_FFFF;
  localparam logic [31:0] SLIDE_SWITCH = 32'hFFFF_FFFE;
  localparam logic [31:0] BUTTON       = 32'hFFFF_FFFD;

  // BUTTON readdata layout: debounced levels at the bottom, sticky presses above.
  localparam int BTN_LVL_LSB = 0;

  typedef enum logic [1:0] {
    SEL_MEM,
    SEL_LED,
    SEL_SW,
    SEL_BTN
  } io_sel_e;

  function automatic int btn_pressed_lsb(input int num_btn);
    return BTN_LVL_LSB + num_btn;
  endfunction

  function automatic io_sel_e decode_addr(input logic [31:0] addr);
    case (addr)
      LED:          return SEL_LED;
      SLIDE_SWITCH: return SEL_SW;
      BUTTON:       return SEL_BTN;
      default:      return SEL_MEM;
    endcase
  endfunction

endpackage

// File: rtl/mmio_io_responder_btn_debounce.sv
// One push button: 2-flop synchronizer, optional debounce counter, level and rising pulse.
// Debounce counter present only when BTN_DEBOUNCE_EN is defined.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_lvl,
  output logic o_rise
);

  logic [1:0] r_sync;
  logic       r_lvl;
  logic       w_lvl_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[0], i_btn};
  end

`ifdef BTN_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          w_differs;

  assign w_differs  = (r_sync[1] != r_lvl);
  assign w_lvl_next = (w_differs && (r_cnt == CNT_TC)) ? r_sync[1] : r_lvl;

  // Any bounce back to the accepted level restarts the stability count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              r_cnt <= '0;
    else if (!w_differs || r_cnt == CNT_TC) r_cnt <= '0;
    else                                    r_cnt <= r_cnt + CW'(1);
  end
`else
  logic w_unused_dbc;
  assign w_unused_dbc = (DEBOUNCE_CYCLES > 1);
  assign w_lvl_next   = r_sync[1];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_lvl <= 1'b0;
    else       r_lvl <= w_lvl_next;
  end

  assign o_lvl  = r_lvl;
  // Combinational so the sticky register can let a same-edge set beat clear-on-read.
  assign o_rise = w_lvl_next & ~r_lvl;

endmodule

// File: rtl/mmio_io_responder.sv
// MMIO responder: LED register, synchronized switches, debounced buttons with sticky presses.
// Button debounce counters are built only when BTN_DEBOUNCE_EN is defined.
module mmio_io_responder
  import mmio_pkg::*;
#(
  parameter int NUM_LEDS        = 8,
  parameter int NUM_SW          = 8,
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         address,
  input  logic                memwrite,
  input  logic                memread,
  input  logic [31:0]         writedata,
  input  logic [31:0]         memdata,
  input  logic [NUM_SW-1:0]   sw_in,
  input  logic [NUM_BTN-1:0]  btn_in,
  output logic [31:0]         readdata,
  output logic [NUM_LEDS-1:0] leds
);

  localparam int PRESSED_LSB = btn_pressed_lsb(NUM_BTN);

  io_sel_e             w_sel;
  logic [NUM_LEDS-1:0] r_led;
  logic [NUM_SW-1:0]   r_sw_meta;
  logic [NUM_SW-1:0]   r_sw_sync;
  logic [NUM_BTN-1:0]  w_btn_lvl;
  logic [NUM_BTN-1:0]  w_btn_rise;
  logic [NUM_BTN-1:0]  r_btn_pressed;
  logic                w_btn_clear;
  logic                w_unused_wdata;

  assign w_sel          = decode_addr(address);
  assign w_btn_clear    = (w_sel == SEL_BTN) && memread;
  assign w_unused_wdata = ^(writedata >> NUM_LEDS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             r_led <= '0;
    else if (w_sel == SEL_LED && memwrite) r_led <= writedata[NUM_LEDS-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= sw_in;
      r_sw_sync <= r_sw_meta;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk   (clk),
      .reset (reset),
      .i_btn (btn_in[i]),
      .o_lvl (w_btn_lvl[i]),
      .o_rise(w_btn_rise[i])
    );
  end

  // A new press on the clearing edge survives the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_btn_pressed <= '0;
    else       r_btn_pressed <= (w_btn_clear ? '0 : r_btn_pressed) | w_btn_rise;
  end

  always_comb begin
    readdata = memdata;
    case (w_sel)
      SEL_LED: readdata = 32'(r_led);
      SEL_SW:  readdata = 32'(r_sw_sync);
      SEL_BTN: begin
        readdata = '0;
        readdata[BTN_LVL_LSB +: NUM_BTN] = w_btn_lvl;
        readdata[PRESSED_LSB +: NUM_BTN] = r_btn_pressed;
      end
      default: readdata = memdata;
    endcase
  end

  assign leds = r_led;

endmodule

// File: tb/tb_mmio_io_responder.sv
// Bench for mmio_io_responder: bus vector table plus switch/button/reset sequences.
module tb_mmio_io_responder;

  localparam int DC = 4;
`ifdef BTN_DEBOUNCE_EN
  localparam int BTN_LAT = 2 + DC;
  localparam bit DEB     = 1'b1;
`else
  localparam int BTN_LAT = 3;
  localparam bit DEB     = 1'b0;
`endif

  localparam logic [31:0] A_LED = 32'hFFFF_FFFF;
  localparam logic [31:0] A_SW  = 32'hFFFF_FFFE;
  localparam logic [31:0] A_BTN = 32'hFFFF_FFFD;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        memwrite;
  logic        memread;
  logic [31:0] writedata;
  logic [31:0] memdata;
  logic [7:0]  sw_in;
  logic [3:0]  btn_in;
  logic [31:0] readdata;
  logic [7:0]  leds;

  mmio_io_responder #(
    .NUM_LEDS(8), .NUM_SW(8), .NUM_BTN(4), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .memwrite(memwrite),
    .memread(memread), .writedata(writedata), .memdata(memdata),
    .sw_in(sw_in), .btn_in(btn_in), .readdata(readdata), .leds(leds)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp_rd;
    logic [7:0]  exp_leds;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] mdata;
    logic [31:0] exp_rd;
    logic [7:0]  exp_leds;
  } vec_t;

  exp_t       sb_q[$];
  vec_t       vecs[10];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] led_model = 8'h00;

  task automatic set_bus(input logic [31:0] a, input logic rd, input logic wr,
                         input logic [31:0] wd, input logic [31:0] md);
    address   = a;
    memread   = rd;
    memwrite  = wr;
    writedata = wd;
    memdata   = md;
  endtask

  task automatic expect_out(input string name, input logic [31:0] rd, input logic [7:0] l);
    exp_t e;
    e.name = name; e.exp_rd = rd; e.exp_leds = l;
    sb_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    #1;
    if (sb_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_empty: no expectation queued");
    end else begin
      e = sb_q.pop_front();
      n_tests++;
      if (readdata !== e.exp_rd) begin
        n_fail++;
        $display("FAIL %s readdata: got 0x%08h want 0x%08h", e.name, readdata, e.exp_rd);
      end
      n_tests++;
      if (leds !== e.exp_leds) begin
        n_fail++;
        $display("FAIL %s leds: got 0x%02h want 0x%02h", e.name, leds, e.exp_leds);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] rd);
    expect_out(name, rd, led_model);
    check_out();
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    vecs[0] = '{"mem_after_reset", 32'h0000_0040, 1'b0, 1'b0, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 8'h00};
    vecs[1] = '{"led_store",       A_LED,         1'b0, 1'b1, 32'h1234_56C3, 32'h1111_1111, 32'h0000_0000, 8'h00};
    vecs[2] = '{"led_load",        A_LED,         1'b1, 1'b0, 32'h0,         32'h1111_1111, 32'h0000_00C3, 8'hC3};
    vecs[3] = '{"mem_store",       32'h0000_0040, 1'b0, 1'b1, 32'h0000_FFFF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 8'hC3};
    vecs[4] = '{"mem_passthru",    32'h0000_0040, 1'b1, 1'b0, 32'h0,         32'h1234_5678, 32'h1234_5678, 8'hC3};
    vecs[5] = '{"sw_store_ign",    A_SW,          1'b0, 1'b1, 32'h0000_00FF, 32'h2222_2222, 32'h0000_0000, 8'hC3};
    vecs[6] = '{"btn_store_ign",   A_BTN,         1'b0, 1'b1, 32'h0000_00FF, 32'h2222_2222, 32'h0000_0000, 8'hC3};
    vecs[7] = '{"led_rd_and_wr",   A_LED,         1'b1, 1'b1, 32'hFFFF_FF5A, 32'h3333_3333, 32'h0000_00C3, 8'hC3};
    vecs[8] = '{"led_reload",      A_LED,         1'b1, 1'b0, 32'h0,         32'h3333_3333, 32'h0000_005A, 8'h5A};
    vecs[9] = '{"mem_near_io",     32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0,         32'hCAFE_F00D, 32'hCAFE_F00D, 8'h5A};

    reset  = 1'b1;
    sw_in  = 8'h00;
    btn_in = 4'h0;
    set_bus(A_BTN, 1'b0, 1'b0, 32'h0, 32'h4444_4444);
    repeat (2) @(negedge clk);
    chk("reset_btn", 32'h0);
    set_bus(32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h5555_AAAA);
    chk("reset_mem", 32'h5555_AAAA);
    reset = 1'b0;
    tick(1);

    for (int i = 0; i < 10; i++) begin
      set_bus(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wdata, vecs[i].mdata);
      expect_out(vecs[i].name, vecs[i].exp_rd, vecs[i].exp_leds);
      check_out();
      tick(1);
    end
    led_model = 8'h5A;

    // Switch synchronizer: two edges of latency.
    set_bus(A_SW, 1'b0, 1'b0, 32'h0, 32'h6666_6666);
    sw_in = 8'h5A;
    chk("sw_edge0", 32'h0);
    tick(1);
    chk("sw_edge1", 32'h0);
    tick(1);
    chk("sw_edge2", 32'h0000_005A);

    // Short 3-cycle pulse on button 1.
    set_bus(A_BTN, 1'b0, 1'b0, 32'h0, 32'h0);
    btn_in = 4'b0010;
    tick(3);
    btn_in = 4'b0000;
    tick(8);
    memread = 1'b1;
    chk("btn_bounce", DEB ? 32'h0 : 32'h20);
    tick(1);
    memread = 1'b0;
    chk("btn_bounce_clr", 32'h0);

    // Held press on button 1.
    btn_in = 4'b0010;
    tick(BTN_LAT - 1);
    chk("btn1_before", 32'h0);
    tick(1);
    chk("btn1_accept", 32'h22);
    memread = 1'b1;
    chk("btn1_read", 32'h22);
    tick(1);
    memread = 1'b0;
    chk("btn1_cleared", 32'h02);

    // Clear-on-read on the same edge that accepts button 0.
    btn_in = 4'b0011;
    tick(BTN_LAT - 1);
    chk("btn0_before", 32'h02);
    memread = 1'b1;
    chk("btn0_clr_edge", 32'h02);
    tick(1);
    memread = 1'b0;
    chk("btn0_set_wins", 32'h13);
    memread = 1'b1;
    chk("btn0_read", 32'h13);
    tick(1);
    memread = 1'b0;
    chk("btn0_cleared", 32'h03);

    // Asynchronous reset mid-cycle.
    set_bus(A_LED, 1'b0, 1'b1, 32'h0000_00A5, 32'h0);
    tick(1);
    led_model = 8'hA5;
    set_bus(A_BTN, 1'b0, 1'b0, 32'h0, 32'h7777_7777);
    chk("pre_reset", 32'h03);
    #1;
    reset = 1'b1;
    led_model = 8'h00;
    chk("async_reset_btn", 32'h0);
    set_bus(32'h0000_0040, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF);
    chk("async_reset_mem", 32'hDEAD_BEEF);
    btn_in = 4'h0;
    @(negedge clk);
    reset = 1'b0;

    if (sb_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_leftover: %0d expectations unchecked, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got %0d tests, want completion", n_tests);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mmio_io_responder.md
# mmio_io_responder

Responder side of the single-cycle core's memory-mapped I/O bus: owns the LED output register, samples slide switches and push buttons into clean registers, and returns load data for the I/O addresses while passing data-memory read data through for every other address. It sits between the datapath's ALU result/write-data buses, the data memory read port and the board pins.

## Interface
- NUM_LEDS, 8, width of LED register (1..32)
- NUM_SW, 8, number of slide switches (1..32)
- NUM_BTN, 4, number of push buttons (1..16)
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a button change (>=2); counter width = $clog2(DEBOUNCE_CYCLES)
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- address  input  32  data address from ALU
- memwrite  input  1  store strobe
- memread  input  1  load strobe (high for lw)
- writedata  input  32  store data
- memdata  input  32  data-memory read data
- sw_in  input  NUM_SW  raw switch pins (asynchronous)
- btn_in  input  NUM_BTN  raw button pins (asynchronous, active-high)
- readdata  output  32  load data to writeback mux
- leds  output  NUM_LEDS  LED register

## Operation
- Address map: LED 0xFFFF_FFFF, SWITCH 0xFFFF_FFFE, BUTTON 0xFFFF_FFFD; all else = memory.
- LED: on clk edge with address==LED && memwrite, led_reg <= writedata[NUM_LEDS-1:0]. Stores to SWITCH/BUTTON ignored.
- Switches: 2-flop synchronizer per bit; sw_sync is read value.
- Buttons: 2-flop synchronizer -> btn_sync; debounced level btn_lvl; sticky btn_pressed set on each 0->1 of btn_lvl.
- Debounce (per button): counter cleared whenever btn_sync==btn_lvl; otherwise increments; on edge where counter==DEBOUNCE_CYCLES-1 and btn_sync!=btn_lvl, btn_lvl <= btn_sync, counter <= 0.
- readdata (combinational): LED -> zero-extended led_reg; SWITCH -> zero-extended sw_sync; BUTTON -> bits[NUM_BTN-1:0]=btn_lvl, bits[2*NUM_BTN-1:NUM_BTN]=btn_pressed, rest 0; otherwise memdata unchanged.
- Clear-on-read: on edge with address==BUTTON && memread, btn_pressed <= 0 except bits receiving a new 0->1 on that same edge (set wins). Value read in that cycle is the pre-clear value.
- memread and memwrite both high: both actions performed independently.

## Timing
- Reset (async, any time): led_reg, sw sync flops, btn sync flops, btn_lvl, counters, btn_pressed all 0; leds=0; readdata follows mux with zeroed registers (memdata for non-I/O addresses).
- LED store visible on leds the cycle after the write edge.
- Switch change visible in readdata after 2nd rising edge.
- Button with debounce: btn_lvl changes on edge 2+DEBOUNCE_CYCLES after pin change held stable; any bounce shorter than DEBOUNCE_CYCLES cycles restarts count, no change.
- Reset mid-debounce discards count; pressed bits lost.
- readdata zero latency from address/memdata; no combinational path from raw pins.

## Configuration
- BTN_DEBOUNCE_EN defined: debounce counters as above.
- Undefined: no counters; btn_lvl <= btn_sync every edge (press visible at 3rd edge); DEBOUNCE_CYCLES unused.

## Structure
- Package mmio_pkg: the three address localparams (LED, SLIDE_SWITCH, BUTTON) shared with the address decoder, plus readdata field offsets.
- Sub-module btn_debounce (one instance per button, generate loop): sync, counter, level, rising-edge pulse; macro guard lives inside it.

## Test plan
- Assert reset mid-run with led_reg=0xA5 -> leds=0x00, BUTTON read = 0x00 immediately, async.
- Store 0x1234_56C3 to 0xFFFF_FFFF -> leds=0xC3 next cycle; load same address -> readdata=0x0000_00C3.
- sw_in 0x00->0x5A -> SWITCH read 0x00 after 1 edge, 0x5A after 2 edges.
- DEBOUNCE_CYCLES=4: btn_in[1] high 3 cycles then low -> no change; high 10 cycles -> BUTTON read 0x22; read with memread clears -> next read 0x02.
- Clear-on-read edge coincides with btn[0] accepted press -> bit 4 remains 1 after the read.
- Address 0x0000_0040, memdata=0xDEAD_BEEF, memwrite=1 -> readdata=0xDEAD_BEEF, leds unchanged.
